tt_sweep_ctrl: RTL and testbench

Self-test sequencer for a 4-input combinational function block, such as the f=(b+d)(a'+b'+c) primitive.
- Steps the function inputs through all 16 combinations {a,b,c,d}=0..15.
- Waits a programmable settle time per vector, then samples f.
- Builds a 16-bit captured truth table and compares it bit-by-bit with an expected table.
- Reports done/pass, error count and first failing index.
- Sits between a test-control master (start/abort) and the function block under test.

---
 rtl/tt_sweep_pkg.sv | 23 ++
 rtl/tt_settle_cnt.sv | 39 +++
 rtl/tt_sweep_ctrl.sv | 144 ++++++++++++++
 tb/tb_tt_sweep_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/tt_sweep_pkg.sv
// ---------------------------------------------------------------------------
// tt_sweep_pkg : shared types and constants for the truth-table sweep block
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package tt_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    SAMPLE = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam int          VEC_W       = 4;
  localparam int          NUM_VEC     = 16;
  localparam logic [15:0] EXP_DEFAULT = 16'hCAFA;
  localparam int          SETTLE_MAX  = 15;

endpackage

`default_nettype wire

// File: rtl/tt_settle_cnt.sv
// ---------------------------------------------------------------------------
// tt_settle_cnt : 4-bit settle counter, terminal when count == SETTLE-1
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tt_settle_cnt
  import tt_sweep_pkg::*;
#(
  parameter int SETTLE = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_term
);

  // Out-of-range settings are clamped so the terminal compare always hits.
  localparam int SETTLE_EFF = (SETTLE > SETTLE_MAX) ? SETTLE_MAX :
                              ((SETTLE < 1) ? 1 : SETTLE);

  logic [3:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 4'd0;
    end else if (i_clr) begin
      r_cnt <= 4'd0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 4'd1;
    end
  end

  assign o_term = (r_cnt == 4'(SETTLE_EFF - 1));

endmodule

`default_nettype wire

// File: rtl/tt_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// tt_sweep_ctrl : steps a 4-input function through all vectors, captures and
//                 checks its truth table. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tt_sweep_ctrl
  import tt_sweep_pkg::*;
#(
  parameter int          SETTLE   = 2,
  parameter logic [15:0] EXPECTED = EXP_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic [VEC_W-1:0] vec_o,
  output logic             vec_valid_o,
  input  logic             f_i,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      captured,
  output logic [4:0]       err_count,
  output logic [3:0]       first_err_idx,
  output logic             first_err_vld
);

  state_t           r_state;
  logic [VEC_W-1:0] r_idx;
  logic             r_vec_valid;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic [15:0]      r_captured;
  logic [4:0]       r_err_count;
  logic [3:0]       r_first_idx;
  logic             r_first_vld;

  logic w_term;
  logic w_mismatch;

  tt_settle_cnt #(.SETTLE(SETTLE)) u_settle (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (r_state != APPLY),
    .i_en   (r_state == APPLY),
    .o_term (w_term)
  );

  assign w_mismatch = (f_i != EXPECTED[r_idx]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_vec_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_captured  <= '0;
      r_err_count <= '0;
      r_first_idx <= '0;
      r_first_vld <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start && !abort) begin
            r_state     <= APPLY;
            r_idx       <= '0;
            r_vec_valid <= 1'b1;
            r_busy      <= 1'b1;
            r_pass      <= 1'b0;
            r_captured  <= '0;
            r_err_count <= '0;
            r_first_idx <= '0;
            r_first_vld <= 1'b0;
          end
        end
        APPLY: begin
          if (abort) begin
            r_state     <= IDLE;
            r_vec_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_pass      <= 1'b0;
          end else if (w_term) begin
            r_state <= SAMPLE;
          end
        end
        SAMPLE: begin
          if (abort) begin
            r_state     <= IDLE;
            r_vec_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_pass      <= 1'b0;
          end else begin
            r_captured[r_idx] <= f_i;
            if (w_mismatch) begin
              if (r_err_count != 5'(NUM_VEC)) begin
                r_err_count <= r_err_count + 5'd1;
              end
              if (!r_first_vld) begin
                r_first_idx <= r_idx;
                r_first_vld <= 1'b1;
              end
            end
            if (r_idx == VEC_W'(NUM_VEC - 1)) begin
              r_state     <= FINISH;
              r_vec_valid <= 1'b0;
              r_done      <= 1'b1;
            end else begin
              r_state <= APPLY;
              r_idx   <= r_idx + VEC_W'(1);
            end
          end
        end
        FINISH: begin
          // err_count already holds the last vector's result here.
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_pass  <= !abort && (r_err_count == 5'd0);
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign vec_o         = r_idx;
  assign vec_valid_o   = r_vec_valid;
  assign busy          = r_busy;
  // An abort arriving during FINISH must suppress the completion pulse.
  assign done          = r_done && !abort;
  assign pass          = r_pass;
  assign captured      = r_captured;
  assign err_count     = r_err_count;
  assign first_err_idx = r_first_idx;
  assign first_err_vld = r_first_vld;

endmodule

`default_nettype wire

// File: tb/tb_tt_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// tb_tt_sweep_ctrl : directed bench for tt_sweep_ctrl with the f=(b+d)(a'+b'+c)
//                    primitive and a fault-injection mux on f_i. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_tt_sweep_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [3:0]  vec_o;
  logic        vec_valid_o;
  logic        f_i;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] captured;
  logic [4:0]  err_count;
  logic [3:0]  first_err_idx;
  logic        first_err_vld;

  int total = 0;
  int bad   = 0;
  int fault_mode = 0;

  logic w_f_good;

  tt_sweep_ctrl #(.SETTLE(2), .EXPECTED(16'hCAFA)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .abort         (abort),
    .vec_o         (vec_o),
    .vec_valid_o   (vec_valid_o),
    .f_i           (f_i),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .captured      (captured),
    .err_count     (err_count),
    .first_err_idx (first_err_idx),
    .first_err_vld (first_err_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Function primitive under test: f = (b+d)(a'+b'+c), vec = {a,b,c,d}.
  assign w_f_good = (vec_o[2] | vec_o[0]) & (~vec_o[3] | ~vec_o[2] | vec_o[1]);
  assign f_i = (fault_mode == 1) ? 1'b0 :
               ((fault_mode == 2) && (vec_o == 4'd9)) ? ~w_f_good : w_f_good;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One sweep: start accepted at edge 0, cycle k is the interval after edge k-1.
  // Inputs change 1ns after each edge; outputs are sampled at the falling edge.
  task automatic sweep(input int poke_cyc, input int abort_cyc, input int rst_cyc,
                       output int done_cyc, output int ndone, output int vec_errs,
                       output int busy_lo);
    done_cyc = 0; ndone = 0; vec_errs = 0; busy_lo = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 60; k++) begin
      #1;
      start = (k == poke_cyc);
      abort = (k == abort_cyc);
      @(negedge clk);
      if (done) begin
        ndone++;
        if (done_cyc == 0) done_cyc = k;
      end
      if (!busy && busy_lo == 0) busy_lo = k;
      if (abort_cyc == 0 && rst_cyc == 0) begin
        if (k <= 48) begin
          if (!(vec_valid_o && busy && vec_o == 4'((k - 1) / 3))) vec_errs++;
        end else if (k == 49) begin
          if (!(busy && !vec_valid_o)) vec_errs++;
        end
      end
      if (k == rst_cyc) begin
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_flags", {busy, vec_valid_o, done, pass, first_err_vld,
                              vec_o, first_err_idx, err_count}, 32'd0);
        chk("rst_mid_capt", captured, 32'd0);
        #1 rst_n = 1'b1;
        break;
      end
      @(posedge clk);
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  int dc, nd, ve, bl;

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_flags", {busy, vec_valid_o, done, pass, first_err_vld,
                        vec_o, first_err_idx, err_count}, 32'd0);
    chk("reset_capt", captured, 32'd0);
    rst_n = 1'b1;

    // 1: clean primitive
    fault_mode = 0;
    sweep(0, 0, 0, dc, nd, ve, bl);
    chk("t1_done_cyc", dc, 49);
    chk("t1_ndone", nd, 1);
    chk("t1_vec_trace", ve, 0);
    chk("t1_busy_low_cyc", bl, 50);
    chk("t1_captured", captured, 16'hCAFA);
    chk("t1_err_count", err_count, 0);
    chk("t1_pass", pass, 1);
    chk("t1_first_vld", first_err_vld, 0);

    // 2: stuck-at-0
    fault_mode = 1;
    sweep(0, 0, 0, dc, nd, ve, bl);
    chk("t2_done_cyc", dc, 49);
    chk("t2_captured", captured, 16'h0000);
    chk("t2_err_count", err_count, 10);
    chk("t2_first_idx", first_err_idx, 1);
    chk("t2_first_vld", first_err_vld, 1);
    chk("t2_pass", pass, 0);

    // 3: vector 9 inverted
    fault_mode = 2;
    sweep(0, 0, 0, dc, nd, ve, bl);
    chk("t3_captured", captured, 16'hC8FA);
    chk("t3_err_count", err_count, 1);
    chk("t3_first_idx", first_err_idx, 9);
    chk("t3_first_vld", first_err_vld, 1);
    chk("t3_pass", pass, 0);

    // 4: abort while vector 5 is applied, then a clean rerun
    fault_mode = 0;
    sweep(0, 16, 0, dc, nd, ve, bl);
    chk("t4_ndone", nd, 0);
    chk("t4_busy_low_cyc", bl, 17);
    chk("t4_captured", captured, 16'h001A);
    chk("t4_pass", pass, 0);
    chk("t4_vec_valid", vec_valid_o, 0);
    sweep(0, 0, 0, dc, nd, ve, bl);
    chk("t4_rerun_done_cyc", dc, 49);
    chk("t4_rerun_pass", pass, 1);

    // 4b: abort during the FINISH cycle suppresses done and pass
    sweep(0, 49, 0, dc, nd, ve, bl);
    chk("t4b_ndone", nd, 0);
    chk("t4b_pass", pass, 0);
    chk("t4b_captured", captured, 16'hCAFA);

    // 5: start mid-sweep is ignored
    sweep(20, 0, 0, dc, nd, ve, bl);
    chk("t5_done_cyc", dc, 49);
    chk("t5_ndone", nd, 1);
    chk("t5_vec_trace", ve, 0);
    chk("t5_pass", pass, 1);

    // 5b: start and abort together in IDLE
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    chk("t5b_busy", busy, 0);
    chk("t5b_vec_valid", vec_valid_o, 0);
    chk("t5b_pass_kept", pass, 1);

    // 6: asynchronous reset mid-sweep, then a full clean sweep
    sweep(0, 0, 25, dc, nd, ve, bl);
    @(negedge clk);
    chk("t6_idle_busy", busy, 0);
    sweep(0, 0, 0, dc, nd, ve, bl);
    chk("t6_done_cyc", dc, 49);
    chk("t6_captured", captured, 16'hCAFA);
    chk("t6_pass", pass, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
